// File: rtl/video_timing_frame_gen_pkg.sv
// Shared constants for the raster timing generator and its frame gate.
package video_timing_frame_gen_pkg;

  // 1280x720@60 (74.25 MHz pixel clock)
  localparam int P720_H_SYNC  = 40;
  localparam int P720_H_BACK  = 220;
  localparam int P720_H_VALID = 1280;
  localparam int P720_H_FRONT = 110;
  localparam int P720_V_SYNC  = 5;
  localparam int P720_V_BACK  = 20;
  localparam int P720_V_VALID = 720;
  localparam int P720_V_FRONT = 5;

  // 640x480@60 (25.175 MHz pixel clock)
  localparam int P480_H_SYNC  = 96;
  localparam int P480_H_BACK  = 48;
  localparam int P480_H_VALID = 640;
  localparam int P480_H_FRONT = 16;
  localparam int P480_V_SYNC  = 2;
  localparam int P480_V_BACK  = 33;
  localparam int P480_V_VALID = 480;
  localparam int P480_V_FRONT = 10;

  // Tiny raster for simulation: 14 x 7 = 98 cycles per frame
  localparam int SIM_H_SYNC  = 2;
  localparam int SIM_H_BACK  = 2;
  localparam int SIM_H_VALID = 8;
  localparam int SIM_H_FRONT = 2;
  localparam int SIM_V_SYNC  = 1;
  localparam int SIM_V_BACK  = 1;
  localparam int SIM_V_VALID = 4;
  localparam int SIM_V_FRONT = 1;

  // Sync polarity
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;
  localparam bit SYNC_ACTIVE_LOW  = 1'b0;

  // Frame-gate state encoding
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARMED  = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = S_IDLE,
    ST_ARMED  = S_ARMED,
    ST_ACTIVE = S_ACTIVE
  } gate_state_e;

  function automatic int span4(int a, int b, int c, int d);
    return a + b + c + d;
  endfunction

endpackage

// File: rtl/video_timing_frame_gen_if.sv
// Gate control and raster outputs of the timing generator.
// master = the generator, slave = the capture/display consumer.
interface video_timing_frame_gen_if #(
  parameter int CNT_W  = 12,
  parameter int FNUM_W = 8
);
  logic              key_flag;
  logic              gate_mode;
  logic [FNUM_W-1:0] frame_num;
  logic              hsync;
  logic              vsync;
  logic              rgb_valid;
  logic              pix_data_req;
  logic [CNT_W-1:0]  pix_x;
  logic [CNT_W-1:0]  pix_y;
  logic              frame_begin;
  logic              frame_end;
  logic              frame;
  logic [FNUM_W-1:0] frame_cnt;
  logic              busy;

  modport master (
    input  key_flag, gate_mode, frame_num,
    output hsync, vsync, rgb_valid, pix_data_req, pix_x, pix_y,
           frame_begin, frame_end, frame, frame_cnt, busy
  );

  modport slave (
    output key_flag, gate_mode, frame_num,
    input  hsync, vsync, rgb_valid, pix_data_req, pix_x, pix_y,
           frame_begin, frame_end, frame, frame_cnt, busy
  );
endinterface

// File: rtl/video_timing_frame_gen_frame_gate_fsm.sv
// Frame-aligned capture gate: opens on a key request at the next frame
// boundary, closes after N frames (burst) or on a second key (continuous).
import video_timing_frame_gen_pkg::*;

module frame_gate_fsm #(
  parameter int FNUM_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_flag,
  input  logic              gate_mode,
  input  logic [FNUM_W-1:0] frame_num,
  input  logic              frame_end,
  output logic              frame,
  output logic              busy,
  output logic [FNUM_W-1:0] frame_cnt
);
  gate_state_e       state_q, state_d;
  logic              mode_q, mode_d;
  logic              stop_q, stop_d;
  logic [FNUM_W-1:0] num_q, num_d;
  logic [FNUM_W-1:0] cnt_q, cnt_d;
  logic [FNUM_W:0]   cnt_inc;

  // One extra bit so a saturated count never aliases to a small target
  assign cnt_inc = {1'b0, cnt_q} + {{FNUM_W{1'b0}}, 1'b1};

  // State and gate context registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      stop_q  <= 1'b0;
      num_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      stop_q  <= stop_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; entry/exit only ever happen on frame_end so no partial frame is gated
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    stop_d  = stop_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (key_flag) begin
          mode_d  = gate_mode;
          num_d   = (frame_num == '0) ? FNUM_W'(1) : frame_num;
          cnt_d   = '0;
          stop_d  = 1'b0;
          state_d = frame_end ? ST_ACTIVE : ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (frame_end) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        // a stop key on the boundary cycle closes the gate at that same boundary
        if (key_flag && mode_q) stop_d = 1'b1;
        if (frame_end) begin
          if (cnt_q != '1) cnt_d = cnt_inc[FNUM_W-1:0];
          if (mode_q ? stop_d : (cnt_inc == {1'b0, num_q})) begin
            state_d = ST_IDLE;
            stop_d  = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign frame     = (state_q == ST_ACTIVE);
  assign busy      = (state_q == ST_ARMED) || (state_q == ST_ACTIVE);
  assign frame_cnt = cnt_q;

endmodule

// File: rtl/video_timing_frame_gen.sv
// Raster timing generator: h/v counters, sync and window decodes, plus the frame gate.
import video_timing_frame_gen_pkg::*;

module video_timing_frame_gen #(
  parameter int H_SYNC   = P720_H_SYNC,
  parameter int H_BACK   = P720_H_BACK,
  parameter int H_VALID  = P720_H_VALID,
  parameter int H_FRONT  = P720_H_FRONT,
  parameter int V_SYNC   = P720_V_SYNC,
  parameter int V_BACK   = P720_V_BACK,
  parameter int V_VALID  = P720_V_VALID,
  parameter int V_FRONT  = P720_V_FRONT,
  parameter bit SYNC_POL = SYNC_ACTIVE_HIGH,
  parameter int CNT_W    = 12,
  parameter int FNUM_W   = 8
) (
  input logic                      vga_clk,
  input logic                      sys_rst,
  video_timing_frame_gen_if.master vif
);
  localparam int H_TOTAL = span4(H_SYNC, H_BACK, H_VALID, H_FRONT);
  localparam int V_TOTAL = span4(V_SYNC, V_BACK, V_VALID, V_FRONT);

  localparam logic [CNT_W-1:0] H_MAX    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_MAX    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYN_E  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYN_E  = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_LO = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] H_ACT_HI = CNT_W'(H_SYNC + H_BACK + H_VALID);
  localparam logic [CNT_W-1:0] H_REQ_LO = CNT_W'(H_SYNC + H_BACK - 1);
  localparam logic [CNT_W-1:0] H_REQ_HI = CNT_W'(H_SYNC + H_BACK + H_VALID - 1);
  localparam logic [CNT_W-1:0] V_ACT_LO = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] V_ACT_HI = CNT_W'(V_SYNC + V_BACK + V_VALID);

  logic [CNT_W-1:0] cnt_h_q, cnt_h_d;
  logic [CNT_W-1:0] cnt_v_q, cnt_v_d;
  logic             h_act, h_req, v_act, rgb_valid, frame_end;

  // Raster position counters
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_h_q <= '0;
      cnt_v_q <= '0;
    end else begin
      cnt_h_q <= cnt_h_d;
      cnt_v_q <= cnt_v_d;
    end
  end

  // Horizontal wraps every line; vertical advances at end of line
  always_comb begin
    cnt_h_d = (cnt_h_q == H_MAX) ? '0 : cnt_h_q + CNT_W'(1);
    cnt_v_d = cnt_v_q;
    if (cnt_h_q == H_MAX) cnt_v_d = (cnt_v_q == V_MAX) ? '0 : cnt_v_q + CNT_W'(1);
  end

  assign h_act     = (cnt_h_q >= H_ACT_LO) && (cnt_h_q < H_ACT_HI);
  assign h_req     = (cnt_h_q >= H_REQ_LO) && (cnt_h_q < H_REQ_HI);
  assign v_act     = (cnt_v_q >= V_ACT_LO) && (cnt_v_q < V_ACT_HI);
  assign rgb_valid = h_act && v_act;
  assign frame_end = (cnt_h_q == H_MAX) && (cnt_v_q == V_MAX);

  assign vif.hsync        = (cnt_h_q < H_SYN_E) ? SYNC_POL : ~SYNC_POL;
  assign vif.vsync        = (cnt_v_q < V_SYN_E) ? SYNC_POL : ~SYNC_POL;
  assign vif.rgb_valid    = rgb_valid;
  assign vif.pix_data_req = h_req && v_act;
  assign vif.pix_x        = rgb_valid ? cnt_h_q - H_ACT_LO : '0;
  assign vif.pix_y        = rgb_valid ? cnt_v_q - V_ACT_LO : '0;
  assign vif.frame_begin  = (cnt_h_q == '0) && (cnt_v_q == '0);
  assign vif.frame_end    = frame_end;

  frame_gate_fsm #(.FNUM_W(FNUM_W)) u_gate (
    .clk       (vga_clk),
    .rst       (sys_rst),
    .key_flag  (vif.key_flag),
    .gate_mode (vif.gate_mode),
    .frame_num (vif.frame_num),
    .frame_end (frame_end),
    .frame     (vif.frame),
    .busy      (vif.busy),
    .frame_cnt (vif.frame_cnt)
  );

endmodule

// File: tb/tb_video_timing_frame_gen.sv
// Directed bench on the 14x7 simulation raster with a per-cycle expectation queue.
import video_timing_frame_gen_pkg::*;

module tb_video_timing_frame_gen;
  localparam int HT = 14;
  localparam int VT = 7;
  localparam int FT = HT * VT;

  typedef struct {
    logic       hs, vs, rgb, req, fb, fe, frm, busy;
    logic [11:0] px, py;
    logic [7:0]  cnt;
  } exp_t;

  logic vga_clk, sys_rst;
  video_timing_frame_gen_if #(.CNT_W(12), .FNUM_W(8)) vif ();

  video_timing_frame_gen #(
    .H_SYNC(SIM_H_SYNC), .H_BACK(SIM_H_BACK), .H_VALID(SIM_H_VALID), .H_FRONT(SIM_H_FRONT),
    .V_SYNC(SIM_V_SYNC), .V_BACK(SIM_V_BACK), .V_VALID(SIM_V_VALID), .V_FRONT(SIM_V_FRONT),
    .SYNC_POL(SYNC_ACTIVE_HIGH), .CNT_W(12), .FNUM_W(8)
  ) dut (
    .vga_clk (vga_clk),
    .sys_rst (sys_rst),
    .vif     (vif)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  int   n_pass = 0;
  int   n_tot  = 0;
  exp_t sb[$];
  int   hs_n, vs_n, rgb_n, px_max, py_max, lead_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_hsync"}, vif.hsync, 1'b1);
    chk({tag, "_vsync"}, vif.vsync, 1'b1);
    chk({tag, "_rgb"}, vif.rgb_valid, 1'b0);
    chk({tag, "_fbegin"}, vif.frame_begin, 1'b1);
    chk({tag, "_frame"}, vif.frame, 1'b0);
    chk({tag, "_busy"}, vif.busy, 1'b0);
    chk({tag, "_fcnt"}, vif.frame_cnt, 8'd0);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    vif.key_flag = 1'b0;
    #1;
    chk_reset_outputs("rst");
    repeat (2) @(negedge vga_clk);
    sys_rst = 1'b0;
  endtask

  // Runs cycles 0..len-1 after reset release; gate expected over [gs, ge], nfr frames.
  task automatic run_scn(input string tag, input int len, input int key_c, input bit mode,
                         input logic [7:0] num, input int stop_c, input int x1, input int x2,
                         input int gs, input int ge, input int nfr);
    exp_t e, o;
    int h, v, k;
    for (int c = 0; c < len; c++) begin
      vif.key_flag  = (c == key_c) || (c == stop_c) || (c == x1) || (c == x2);
      vif.gate_mode = (c == key_c) ? mode : ~mode;
      vif.frame_num = (c == key_c) ? num : 8'hff;
      h = c % HT;
      v = (c / HT) % VT;
      e.hs   = (h < 2);
      e.vs   = (v < 1);
      e.rgb  = (h >= 4) && (h < 12) && (v >= 2) && (v < 6);
      e.req  = (h >= 3) && (h < 11) && (v >= 2) && (v < 6);
      e.px   = e.rgb ? 12'(h - 4) : 12'd0;
      e.py   = e.rgb ? 12'(v - 2) : 12'd0;
      e.fb   = (h == 0) && (v == 0);
      e.fe   = (h == HT - 1) && (v == VT - 1);
      e.frm  = (c >= gs) && (c <= ge);
      e.busy = (key_c >= 0) && (c > key_c) && (c <= ge);
      k = (c < gs) ? 0 : (c - gs) / FT;
      if (k > nfr) k = nfr;
      e.cnt  = 8'(k);
      sb.push_back(e);
      o = sb.pop_front();
      chk({tag, "_hsync"}, vif.hsync, o.hs);
      chk({tag, "_vsync"}, vif.vsync, o.vs);
      chk({tag, "_rgb"}, vif.rgb_valid, o.rgb);
      chk({tag, "_req"}, vif.pix_data_req, o.req);
      chk({tag, "_pix_x"}, vif.pix_x, o.px);
      chk({tag, "_pix_y"}, vif.pix_y, o.py);
      chk({tag, "_fbegin"}, vif.frame_begin, o.fb);
      chk({tag, "_fend"}, vif.frame_end, o.fe);
      chk({tag, "_frame"}, vif.frame, o.frm);
      chk({tag, "_busy"}, vif.busy, o.busy);
      chk({tag, "_fcnt"}, vif.frame_cnt, o.cnt);
      if (c < FT) begin
        hs_n  += int'(vif.hsync);
        vs_n  += int'(vif.vsync);
        rgb_n += int'(vif.rgb_valid);
        if (vif.rgb_valid && int'(vif.pix_x) > px_max) px_max = int'(vif.pix_x);
        if (vif.rgb_valid && int'(vif.pix_y) > py_max) py_max = int'(vif.pix_y);
      end
      if (vif.pix_data_req !== e.req) lead_err++;
      @(negedge vga_clk);
      if (c + 1 < len && (c + 1) % HT != 0 && vif.rgb_valid !== o.req) lead_err++;
    end
    vif.key_flag = 1'b0;
  endtask

  initial begin
    sys_rst = 1'b1;
    vif.key_flag = 1'b0;
    vif.gate_mode = 1'b0;
    vif.frame_num = 8'd0;
    hs_n = 0; vs_n = 0; rgb_n = 0; px_max = 0; py_max = 0; lead_err = 0;

    // free-running raster, no gate
    do_reset();
    run_scn("raster", 2 * FT, -1, 1'b0, 8'd0, -1, -1, -1, 1 << 30, -1, 0);
    chk("hsync_per_frame", 32'(hs_n), 32'd14);
    chk("vsync_per_frame", 32'(vs_n), 32'd14);
    chk("rgb_per_frame", 32'(rgb_n), 32'd32);
    chk("pix_x_max", 32'(px_max), 32'd7);
    chk("pix_y_max", 32'(py_max), 32'd3);
    chk("req_leads_rgb", 32'(lead_err), 32'd0);

    // burst of 3, extra keys in ARMED and in ACTIVE ignored
    do_reset();
    run_scn("burst3", 500, 30, 1'b0, 8'd3, -1, 60, 200, 98, 391, 3);

    // burst with frame_num 0 gates exactly one frame
    do_reset();
    run_scn("burst0", 300, 30, 1'b0, 8'd0, -1, -1, -1, 98, 195, 1);

    // key coincident with frame_end: straight to ACTIVE
    do_reset();
    run_scn("coinc", 300, 97, 1'b0, 8'd1, -1, -1, -1, 98, 195, 1);

    // continuous, stop key inside frame 3
    do_reset();
    run_scn("cont", 500, 10, 1'b1, 8'd7, 300, -1, -1, 98, 391, 3);

    // continuous, stop key exactly on a frame_end closes at that boundary
    do_reset();
    run_scn("cont_fe", 300, 10, 1'b1, 8'd7, 195, -1, -1, 98, 195, 1);

    // reset in the middle of a gate, then a fresh request
    do_reset();
    run_scn("pre_rst", 250, 30, 1'b0, 8'd3, -1, -1, -1, 98, 391, 3);
    sys_rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    repeat (3) @(negedge vga_clk);
    chk_reset_outputs("midrst_hold");
    sys_rst = 1'b0;
    run_scn("post_rst", 320, 5, 1'b0, 8'd2, -1, -1, -1, 98, 293, 2);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
